// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU operation codes and sequencer state type for alu_seq_ctrl.
// The opcodes match the ALU's sinal_ula decoding.
package alu_seq_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DIV_INC,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer that borrows the shared 8-bit ALU while busy.
// Multiply: done at T+9. Divide: done at T+2+3*quotient (T+1 on divide by zero).
module alu_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MUL_ITERS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_operando_a,
  input  logic [WIDTH-1:0] i_operando_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_resultado,
  output logic [WIDTH-1:0] o_resto,
  output logic             o_erro,
  output logic [WIDTH-1:0] o_alu_ent1,
  output logic [WIDTH-1:0] o_alu_ent2,
  output logic [2:0]       o_alu_sinal,
  input  logic [WIDTH-1:0] i_alu_saida,
  input  logic             i_alu_zero
);
  import alu_seq_ctrl_pkg::*;

  if (WIDTH != 8 || MUL_ITERS != WIDTH) begin : g_bad_param
    $error("alu_seq_ctrl supports only WIDTH=8 with MUL_ITERS=WIDTH");
  end

  localparam int CW = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_ITERS - 1);

  seq_state_t       r_state;
  logic             r_busy, r_done, r_erro;
  logic [WIDTH-1:0] r_resultado, r_resto;
  logic [2:0]       r_sinal;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp;
  logic [WIDTH-1:0] r_rem, r_div, r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_ent1, w_ent2;

  // ALU operands come straight from state registers so the result is usable this cycle.
  always_comb begin
    w_ent1 = '0;
    w_ent2 = '0;
    case (r_state)
      S_MUL:                begin w_ent1 = r_acc; w_ent2 = r_mc;           end
      S_DIV_CMP, S_DIV_SUB: begin w_ent1 = r_rem; w_ent2 = r_div;          end
      S_DIV_INC:            begin w_ent1 = r_q;   w_ent2 = WIDTH'(1);      end
      default:              begin w_ent1 = '0;    w_ent2 = '0;             end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_erro      <= 1'b0;
      r_resultado <= '0;
      r_resto     <= '0;
      r_sinal     <= OP_AND;
      r_acc       <= '0;
      r_mc        <= '0;
      r_mp        <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            r_erro <= 1'b0;
            r_acc  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_mc   <= i_operando_a;
            r_mp   <= i_operando_b;
            r_rem  <= i_operando_a;
            r_div  <= i_operando_b;
            if (!i_op) begin
              r_state <= S_MUL;
              r_sinal <= OP_ADD;
            end else if (i_operando_b != '0) begin
              r_state <= S_DIV_CMP;
              r_sinal <= OP_SLT;
            end else begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_erro      <= 1'b1;
              r_resultado <= '1;
              r_resto     <= i_operando_a;
              r_sinal     <= OP_AND;
            end
          end
        end
        S_MUL: begin
          if (r_mp[0]) r_acc <= i_alu_saida;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_resultado <= r_mp[0] ? i_alu_saida : r_acc;
            r_resto     <= '0;
            r_sinal     <= OP_AND;
          end
        end
        S_DIV_CMP: begin
          // slt result of zero means remainder >= divisor: another subtraction fits.
          if (i_alu_zero) begin
            r_state <= S_DIV_SUB;
            r_sinal <= OP_SUB;
          end else begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_resultado <= r_q;
            r_resto     <= r_rem;
            r_sinal     <= OP_AND;
          end
        end
        S_DIV_SUB: begin
          r_rem   <= i_alu_saida;
          r_state <= S_DIV_INC;
          r_sinal <= OP_ADD;
        end
        S_DIV_INC: begin
          r_q     <= i_alu_saida;
          r_state <= S_DIV_CMP;
          r_sinal <= OP_SLT;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          r_sinal <= OP_AND;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_erro      = r_erro;
  assign o_resultado = r_resultado;
  assign o_resto     = r_resto;
  assign o_alu_sinal = r_sinal;
  assign o_alu_ent1  = w_ent1;
  assign o_alu_ent2  = w_ent2;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU, directed vector table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] opa = 8'd0, opb = 8'd0;
  logic       busy, done, erro, zero;
  logic [7:0] res, rem, ent1, ent2, saida;
  logic [2:0] sinal;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int mon_viol = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(8), .MUL_ITERS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_operando_a(opa), .i_operando_b(opb),
    .o_busy(busy), .o_done(done), .o_resultado(res), .o_resto(rem), .o_erro(erro),
    .o_alu_ent1(ent1), .o_alu_ent2(ent2), .o_alu_sinal(sinal),
    .i_alu_saida(saida), .i_alu_zero(zero)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    saida = 8'd0;
    case (sinal)
      OP_AND:  saida = ent1 & ent2;
      OP_OR:   saida = ent1 | ent2;
      OP_ADD:  saida = ent1 + ent2;
      OP_SUB:  saida = ent1 - ent2;
      OP_SLT:  saida = (ent1 < ent2) ? 8'd1 : 8'd0;
      default: saida = 8'd0;
    endcase
  end
  assign zero = (saida == 8'd0);

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!(sinal inside {OP_AND, OP_ADD, OP_SUB, OP_SLT})) mon_viol++;
    if (!busy && (sinal != OP_AND || ent1 != 8'd0 || ent2 != 8'd0)) mon_viol++;
    if (done && !busy) mon_viol++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [7:0] m,
                                output logic e, output int lat);
    if (!o) begin
      r = 8'((int'(a) * int'(b)) % 256); m = 8'd0; e = 1'b0; lat = 9;
    end else if (b == 8'd0) begin
      r = 8'hFF; m = a; e = 1'b1; lat = 1;
    end else begin
      r = 8'(int'(a) / int'(b)); m = 8'(int'(a) % int'(b)); e = 1'b0;
      lat = 2 + 3 * (int'(a) / int'(b));
    end
  endfunction

  // Starts one op from IDLE and returns in the IDLE cycle after done.
  task automatic do_op(input logic o, input logic [7:0] a, input logic [7:0] b, input bit hold,
                       output int lat, output logic [7:0] r, output logic [7:0] m,
                       output logic e, output bit busy_ok, output bit hold_ok, output bit used);
    logic [7:0] pr, pm;
    pr = res; pm = rem;
    busy_ok = 1'b1; hold_ok = 1'b1; used = 1'b0; lat = 0;
    r = 8'd0; m = 8'd0; e = 1'b0;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    opa = 8'($urandom); opb = 8'($urandom); op = 1'($urandom);
    for (int n = 1; n <= 800; n++) begin
      if (!busy) busy_ok = 1'b0;
      if (sinal != OP_AND) used = 1'b1;
      if (done) begin
        lat = n; r = res; m = rem; e = erro;
        break;
      end
      if (res !== pr || rem !== pm) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      start = 1'b0;
      rst_n = 1'b0; #1; rst_n = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (busy || done) busy_ok = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] xr, input logic [7:0] xm, input logic xe,
                          input int xlat, input bit hold);
    int lat;
    logic [7:0] r, m;
    logic e;
    bit bok, hok, used;
    do_op(o, a, b, hold, lat, r, m, e, bok, hok, used);
    chk({tag, " resultado"}, 32'(r), 32'(xr));
    chk({tag, " resto"}, 32'(m), 32'(xm));
    chk({tag, " erro"}, 32'(e), 32'(xe));
    chk({tag, " latency"}, 32'(lat), 32'(xlat));
    chk({tag, " busy window"}, 32'(bok), 32'd1);
    chk({tag, " result hold"}, 32'(hok), 32'd1);
    chk({tag, " alu used"}, 32'(used), 32'(!(o && b == 8'd0)));
  endtask

  typedef struct {
    logic       op;
    logic [7:0] a, b, r, m;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int dc, lat;
    logic [7:0] a, b, xr, xm;
    logic o, xe;

    vt[0] = '{1'b0, 8'd13,  8'd11,  8'h8F, 8'd0,  1'b0, 9};
    vt[1] = '{1'b0, 8'd20,  8'd20,  8'h90, 8'd0,  1'b0, 9};
    vt[2] = '{1'b1, 8'd100, 8'd7,   8'd14, 8'd2,  1'b0, 44};
    vt[3] = '{1'b1, 8'd7,   8'd9,   8'd0,  8'd7,  1'b0, 2};
    vt[4] = '{1'b1, 8'd55,  8'd0,   8'hFF, 8'd55, 1'b1, 1};
    vt[5] = '{1'b1, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 767};
    vt[6] = '{1'b0, 8'd255, 8'd255, 8'd1,  8'd0,  1'b0, 9};
    vt[7] = '{1'b0, 8'd0,   8'd200, 8'd0,  8'd0,  1'b0, 9};
    vt[8] = '{1'b1, 8'd9,   8'd3,   8'd3,  8'd0,  1'b0, 11};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset resultado", 32'(res), 32'd0);
    chk("reset resto", 32'(rem), 32'd0);
    chk("reset erro", 32'(erro), 32'd0);
    chk("reset sinal", 32'(sinal), 32'(OP_AND));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      check_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
               vt[i].r, vt[i].m, vt[i].e, vt[i].lat, 1'b0);

    // start held through the whole multiply and its done cycle
    dc = done_cnt;
    check_op("held start", 1'b0, 8'd6, 8'd7, 8'd42, 8'd0, 1'b0, 9, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    chk("held start single done", 32'(done_cnt - dc), 32'd1);
    chk("held start idle", 32'(busy), 32'd0);

    // reset in the middle of a long divide
    check_op("pre-reset mul", 1'b0, 8'd13, 8'd11, 8'h8F, 8'd0, 1'b0, 9, 1'b0);
    start = 1'b1; op = 1'b1; opa = 8'd200; opb = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid div busy", 32'(busy), 32'd1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort resultado", 32'(res), 32'd0);
    chk("abort resto", 32'(rem), 32'd0);
    chk("abort erro", 32'(erro), 32'd0);
    chk("abort alu", 32'({ent1, ent2, sinal}), 32'({8'd0, 8'd0, OP_AND}));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    chk("abort no done", 32'(done_cnt - dc), 32'd0);
    chk("abort idle", 32'(busy), 32'd0);

    for (int i = 0; i < 300; i++) begin
      o = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(o, a, b, xr, xm, xe, lat);
      check_op($sformatf("rand%0d op=%0d a=%0d b=%0d", i, o, a, b), o, a, b, xr, xm, xe, lat, 1'b0);
    end

    chk("monitor alu/busy/done rules", 32'(mon_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
